// File: rtl/types.sv
// Shared types for the RV32I pipeline control logic: EX forwarding selects
// and the hazard controller's memory-wait FSM states.
package types;

  typedef enum logic [1:0] {
    FORWARD_NONE = 2'b00,
    FORWARD_WB   = 2'b01,
    FORWARD_MEM  = 2'b10
  } forward_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam int REG_W = 5;

endpackage

// File: rtl/forward_sel.sv
// EX operand bypass select for one source register.
// The MEM-stage result is younger than the WB-stage one, so it wins; x0 never forwards.
module forward_sel
  import types::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             regwrite_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_w,
  output forward_t         fwd
);

  // NOTE: assign a default before any branch so no path leaves fwd unassigned (avoids a latch).
  always_comb begin
    fwd = FORWARD_NONE;
    if (rs != '0) begin
      if (regwrite_m && rd_m == rs)      fwd = FORWARD_MEM;
      else if (regwrite_w && rd_w == rs) fwd = FORWARD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use bubbles,
// branch flushes, memory-wait freeze, saturating perf counters and a sticky timeout flag.
module hazard_controller
  import types::*;
#(
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             regwrite_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_w,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output forward_t         forward_a_e,
  output forward_t         forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [15:0]      TIMEOUT  = 16'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WAIT_MAX = '1;

  forward_t  fwd_a, fwd_b;
  hz_state_t state;
  logic [15:0] wait_cnt;
  logic mem_wait, lu;

  forward_sel u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .fwd(fwd_a)
  );

  forward_sel u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .fwd(fwd_b)
  );

  assign mem_wait = dmem_req_m & ~dmem_ready;
  assign lu       = load_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  // A memory wait outranks a taken branch so the redirect is held until the access completes.
  always_comb begin
    forward_a_e = fwd_a;
    forward_b_e = fwd_b;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    if (reset) begin
      forward_a_e = FORWARD_NONE;
      forward_b_e = FORWARD_NONE;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_w     = 1'b1;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_wait) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready || !dmem_req_m) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
      endcase

      if (state == MEM_WAIT && mem_wait && wait_cnt == TIMEOUT) mem_timeout <= 1'b1;

      if (stall_f && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a directed vector table, randomized
// cycles against a behavioural model, and hand-written multi-cycle sequences.
module tb_hazard_controller;
  import types::*;

  localparam int  BIG_T     = 255;
  localparam int  SMALL_T   = 4;
  localparam int  SMALL_W   = 4;
  localparam longint BIG_MAX   = 64'hFFFF_FFFF;
  localparam longint SMALL_MAX = 15;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, pc_src_e, regwrite_m, regwrite_w, dmem_req_m, dmem_ready, rst;
  } in_t;

  typedef struct {
    forward_t   fa, fb;
    logic [3:0] stall;   // {f, d, e, m}
    logic [2:0] flush;   // {d, e, w}
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, pc_src_e, regwrite_m, regwrite_w, dmem_req_m, dmem_ready;

  forward_t fa, fb, fa2, fb2;
  logic sf, sd, se, sm, fd, fe, fw;
  logic sf2, sd2, se2, sm2, fd2, fe2, fw2;
  logic [31:0] stall_cnt, flush_cnt;
  logic [SMALL_W-1:0] stall_cnt2, flush_cnt2;
  logic timeout, timeout2;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: counters as plain integers, timeout via run length of mem_wait.
  longint m_stall[2], m_flush[2];
  int     m_run;
  bit     m_to[2];

  always #5 clk = ~clk;

  hazard_controller u_dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .forward_a_e(fa), .forward_b_e(fb),
    .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm),
    .flush_d(fd), .flush_e(fe), .flush_w(fw),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(timeout)
  );

  hazard_controller #(.CNT_W(SMALL_W), .WAIT_TIMEOUT(SMALL_T)) u_small (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .forward_a_e(fa2), .forward_b_e(fb2),
    .stall_f(sf2), .stall_d(sd2), .stall_e(se2), .stall_m(sm2),
    .flush_d(fd2), .flush_e(fe2), .flush_w(fw2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .mem_timeout(timeout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v.rs1_d = '0; v.rs2_d = '0; v.rs1_e = '0; v.rs2_e = '0; v.rd_e = '0; v.rd_m = '0; v.rd_w = '0;
    v.load_e = 0; v.pc_src_e = 0; v.regwrite_m = 0; v.regwrite_w = 0;
    v.dmem_req_m = 0; v.dmem_ready = 0; v.rst = 0;
    return v;
  endfunction

  function automatic forward_t fwd_of(logic [4:0] rs, in_t v);
    if (rs == 0) return FORWARD_NONE;
    if (v.regwrite_m && v.rd_m == rs) return FORWARD_MEM;
    if (v.regwrite_w && v.rd_w == rs) return FORWARD_WB;
    return FORWARD_NONE;
  endfunction

  function automatic out_t model_comb(in_t v);
    out_t o;
    bit mw, lu;
    o.fa = fwd_of(v.rs1_e, v);
    o.fb = fwd_of(v.rs2_e, v);
    o.stall = 4'b0000;
    o.flush = 3'b000;
    mw = v.dmem_req_m && !v.dmem_ready;
    lu = v.load_e && v.rd_e != 0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d);
    if (v.rst) begin
      o.fa = FORWARD_NONE;
      o.fb = FORWARD_NONE;
      o.flush = 3'b111;
    end else if (mw)          begin o.stall = 4'b1111; o.flush = 3'b001; end
    else if (v.pc_src_e)      o.flush = 3'b110;
    else if (lu)              begin o.stall = 4'b1100; o.flush = 3'b010; end
    return o;
  endfunction

  task automatic apply(input in_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
    rd_m = v.rd_m; rd_w = v.rd_w; load_e = v.load_e; pc_src_e = v.pc_src_e;
    regwrite_m = v.regwrite_m; regwrite_w = v.regwrite_w;
    dmem_req_m = v.dmem_req_m; dmem_ready = v.dmem_ready; reset = v.rst;
  endtask

  task automatic check_comb(input string tag, input out_t e);
    check({tag, "/fwd_a"}, 32'(fa), 32'(e.fa));
    check({tag, "/fwd_b"}, 32'(fb), 32'(e.fb));
    check({tag, "/stalls"}, 32'({sf, sd, se, sm}), 32'(e.stall));
    check({tag, "/flushes"}, 32'({fd, fe, fw}), 32'(e.flush));
  endtask

  // Advance one clock, update the model from the spec rules, then compare registered outputs.
  task automatic clock_and_check(input string tag, input in_t v);
    out_t e;
    bit mw;
    e = model_comb(v);
    @(posedge clk);
    if (v.rst) begin
      m_stall = '{0, 0}; m_flush = '{0, 0}; m_to = '{0, 0}; m_run = 0;
    end else begin
      if (e.stall[3]) begin
        if (m_stall[0] < BIG_MAX)   m_stall[0]++;
        if (m_stall[1] < SMALL_MAX) m_stall[1]++;
      end
      if (e.flush[2]) begin
        if (m_flush[0] < BIG_MAX)   m_flush[0]++;
        if (m_flush[1] < SMALL_MAX) m_flush[1]++;
      end
      mw = v.dmem_req_m && !v.dmem_ready;
      m_run = mw ? m_run + 1 : 0;
      // One RUN cycle detects the wait, then WAIT_TIMEOUT+1 cycles in MEM_WAIT.
      if (m_run == BIG_T + 2)   m_to[0] = 1;
      if (m_run == SMALL_T + 2) m_to[1] = 1;
    end
    #1;
    check({tag, "/stall_cnt"},  stall_cnt,        32'(m_stall[0]));
    check({tag, "/flush_cnt"},  flush_cnt,        32'(m_flush[0]));
    check({tag, "/stall_cnt4"}, 32'(stall_cnt2),  32'(m_stall[1]));
    check({tag, "/flush_cnt4"}, 32'(flush_cnt2),  32'(m_flush[1]));
    check({tag, "/timeout"},    32'(timeout),     32'(m_to[0]));
    check({tag, "/timeout4"},   32'(timeout2),    32'(m_to[1]));
  endtask

  task automatic step(input string tag, input in_t v);
    apply(v);
    #4;
    check_comb(tag, model_comb(v));
    clock_and_check(tag, v);
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rs1_d = 5'($urandom_range(0, 3)); v.rs2_d = 5'($urandom_range(0, 3));
    v.rs1_e = 5'($urandom_range(0, 3)); v.rs2_e = 5'($urandom_range(0, 3));
    v.rd_e  = 5'($urandom_range(0, 3)); v.rd_m  = 5'($urandom_range(0, 3));
    v.rd_w  = 5'($urandom_range(0, 3));
    v.load_e     = 1'($urandom_range(0, 1));
    v.pc_src_e   = ($urandom_range(0, 3) == 0);
    v.regwrite_m = 1'($urandom_range(0, 1));
    v.regwrite_w = 1'($urandom_range(0, 1));
    v.dmem_req_m = 1'($urandom_range(0, 1));
    v.dmem_ready = ($urandom_range(0, 2) == 0);
    v.rst        = ($urandom_range(0, 39) == 0);
    return v;
  endfunction

  vec_t tbl[12];
  in_t  v;
  logic [31:0] s0, f0;

  initial begin
    m_stall = '{0, 0}; m_flush = '{0, 0}; m_to = '{0, 0}; m_run = 0;
    apply(idle());
    #1;

    // Reset state with explicit constants.
    v = idle(); v.rst = 1;
    step("reset0", v);
    step("reset1", v);
    check("reset/stall_cnt", stall_cnt, 32'd0);
    check("reset/flush_cnt", flush_cnt, 32'd0);
    check("reset/timeout", 32'(timeout), 32'd0);
    check("reset/flush_d", 32'(fd), 32'd1);

    // Directed vectors with hand-derived expected outputs.
    foreach (tbl[k]) begin
      tbl[k].i = idle();
      tbl[k].o.fa = FORWARD_NONE; tbl[k].o.fb = FORWARD_NONE;
      tbl[k].o.stall = 4'b0000;   tbl[k].o.flush = 3'b000;
    end
    tbl[0].i.rst = 1; tbl[0].i.rs1_e = 5; tbl[0].i.rd_m = 5; tbl[0].i.regwrite_m = 1;
    tbl[0].o.flush = 3'b111;
    tbl[1].i.rs1_e = 5; tbl[1].i.rd_m = 5; tbl[1].i.regwrite_m = 1; tbl[1].i.rd_w = 5; tbl[1].i.regwrite_w = 1;
    tbl[1].o.fa = FORWARD_MEM;
    tbl[2].i = tbl[1].i; tbl[2].i.regwrite_m = 0; tbl[2].o.fa = FORWARD_WB;
    tbl[3].i = tbl[1].i; tbl[3].i.rs1_e = 0;
    tbl[4].i.rs2_e = 9; tbl[4].i.rd_m = 9; tbl[4].i.rd_w = 9; tbl[4].i.regwrite_w = 1;
    tbl[4].o.fb = FORWARD_WB;
    tbl[5].i.load_e = 1; tbl[5].i.rd_e = 7; tbl[5].i.rs2_d = 7;
    tbl[5].o.stall = 4'b1100; tbl[5].o.flush = 3'b010;
    tbl[6].i.load_e = 1; tbl[6].i.rd_e = 0;
    tbl[7].i.rd_e = 7; tbl[7].i.rs1_d = 7;
    tbl[8].i.pc_src_e = 1; tbl[8].i.load_e = 1; tbl[8].i.rd_e = 7; tbl[8].i.rs1_d = 7;
    tbl[8].o.flush = 3'b110;
    tbl[9].i = tbl[8].i; tbl[9].i.dmem_req_m = 1;
    tbl[9].o.stall = 4'b1111; tbl[9].o.flush = 3'b001;
    tbl[10].i.dmem_req_m = 1; tbl[10].i.dmem_ready = 1;
    tbl[11].i.pc_src_e = 1; tbl[11].i.dmem_ready = 1;
    tbl[11].o.flush = 3'b110;
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].i);
      #4;
      check_comb($sformatf("vec%0d", k), tbl[k].o);
      clock_and_check($sformatf("vec%0d", k), tbl[k].i);
    end

    // Randomized cycles against the model.
    for (int n = 0; n < 400; n++) step($sformatf("rand%0d", n), rand_in());

    v = idle(); v.rst = 1;
    step("rst_a", v);

    // Load-use: one bubble, then the load is forwarded from MEM.
    s0 = stall_cnt;
    v = idle(); v.load_e = 1; v.rd_e = 7; v.rs2_d = 7;
    step("lu", v);
    check("lu/stall_f", 32'(sf), 32'd1);
    check("lu/stall_cnt", stall_cnt, s0 + 1);
    v = idle(); v.rd_m = 7; v.regwrite_m = 1; v.rs2_e = 7;
    step("lu_next", v);
    check("lu_next/fwd_b", 32'(fb), 32'(FORWARD_MEM));
    check("lu_next/stall_f", 32'(sf), 32'd0);

    // Taken branch overrides a load-use hazard.
    f0 = flush_cnt;
    v = idle(); v.pc_src_e = 1; v.load_e = 1; v.rd_e = 7; v.rs2_d = 7;
    step("br_lu", v);
    check("br_lu/flush_de", 32'({fd, fe}), 32'b11);
    check("br_lu/stall_f", 32'(sf), 32'd0);
    check("br_lu/flush_cnt", flush_cnt, f0 + 1);

    // Memory wait with a pending branch: 3 stall cycles, then one flush cycle.
    s0 = stall_cnt; f0 = flush_cnt;
    v = idle(); v.pc_src_e = 1; v.dmem_req_m = 1;
    for (int k = 0; k < 3; k++) begin
      step("mw", v);
      check("mw/stalls", 32'({sf, sd, se, sm, fw}), 32'b11111);
      check("mw/flush_de", 32'({fd, fe}), 32'b00);
    end
    v.dmem_ready = 1;
    step("mw_done", v);
    check("mw_done/flush_de", 32'({fd, fe}), 32'b11);
    step("mw_after", idle());
    check("mw_after/flush_de", 32'({fd, fe}), 32'b00);
    check("mw/stall_cnt", stall_cnt, s0 + 3);
    check("mw/flush_cnt", flush_cnt, f0 + 1);

    // Timeout on the WAIT_TIMEOUT=4 instance.
    v = idle(); v.rst = 1;
    step("to_rst", v);
    v = idle(); v.dmem_req_m = 1;
    for (int k = 1; k <= 10; k++) begin
      step("to", v);
      check($sformatf("to%0d/timeout4", k), 32'(timeout2), 32'(k >= 6));
    end
    v.dmem_ready = 1;
    step("to_ready", v);
    check("to_ready/timeout4", 32'(timeout2), 32'd1);
    check("to_ready/timeout", 32'(timeout), 32'd0);
    v = idle(); v.rst = 1;
    step("to_clr", v);
    check("to_clr/timeout4", 32'(timeout2), 32'd0);

    // Reset during MEM_WAIT abandons the wait.
    v = idle(); v.dmem_req_m = 1;
    for (int k = 0; k < 3; k++) step("rw", v);
    v.rst = 1; v.pc_src_e = 1;
    step("rw_rst", v);
    check("rw_rst/flushes", 32'({fd, fe, fw}), 32'b111);
    check("rw_rst/stalls", 32'({sf, sd, se, sm}), 32'b0000);
    check("rw_rst/stall_cnt", stall_cnt, 32'd0);
    step("rw_idle", idle());

    // Saturation of the 4-bit counter.
    v = idle(); v.load_e = 1; v.rd_e = 3; v.rs1_d = 3;
    for (int k = 0; k < 20; k++) step("sat", v);
    check("sat/stall_cnt4", 32'(stall_cnt2), 32'd15);
    check("sat/stall_cnt", stall_cnt, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
